rc4_decrypt_loop: RTL and testbench

- Third RC4 stage (PRGA + XOR). Runs after the S-array init and key-schedule stages finish. Feeds the character checker downstream.
- Per message byte k: updates i/j, swaps S[i]/S[j] in the S RAM, forms f = S[S[i]+S[j]], XORs f with encrypted ROM byte k, and writes the result to decrypted RAM.
- Presents each decrypted char to the checker with a new_char pulse, then waits for accept (compared_char) or abort (start_over).
- Aborts and waits for the next go whenever the checker rejects a char and requests a new key.

---
 rtl/rc4_pkg.sv | 24 ++
 rtl/rc4_decrypt_loop_if.sv | 34 +++
 rtl/rc4_decrypt_loop.sv | 132 +++++++++++++
 tb/tb_rc4_decrypt_loop.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and sizes for the RC4 decrypt loop
package rc4_pkg;

    localparam int MSG_LEN_DEF = 32;
    localparam int S_AW        = 8;
    localparam int MSG_AW      = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_NEXT_I,
        ST_RD_SI,
        ST_WAIT_SI,
        ST_RD_SJ,
        ST_WAIT_SJ,
        ST_WR_SI,
        ST_WR_SJ,
        ST_RD_F,
        ST_WAIT_F,
        ST_WR_DR,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rc4_decrypt_loop_if.sv
// rtl/rc4_decrypt_loop_if.sv - control handshake and memory buses of the decrypt loop
interface rc4_decrypt_loop_if #(parameter int K_W = 6);
    import rc4_pkg::*;

    logic              go;
    logic              start_over;
    logic              compared_char;
    logic [S_AW-1:0]   s_addr;
    logic [7:0]        s_wrdata;
    logic              s_wren;
    logic [7:0]        s_rddata;
    logic [MSG_AW-1:0] rom_addr;
    logic [7:0]        rom_rddata;
    logic [MSG_AW-1:0] dr_addr;
    logic [7:0]        dr_wrdata;
    logic              dr_wren;
    logic [7:0]        char_out;
    logic              new_char;
    logic [K_W-1:0]    k;
    logic              done;

    modport master (
        input  go, start_over, compared_char, s_rddata, rom_rddata,
        output s_addr, s_wrdata, s_wren, rom_addr, dr_addr, dr_wrdata, dr_wren,
               char_out, new_char, k, done
    );

    modport slave (
        output go, start_over, compared_char, s_rddata, rom_rddata,
        input  s_addr, s_wrdata, s_wren, rom_addr, dr_addr, dr_wrdata, dr_wren,
               char_out, new_char, k, done
    );

endinterface

// File: rtl/rc4_decrypt_loop.sv
// rtl/rc4_decrypt_loop.sv - RC4 PRGA: swap S[i]/S[j], XOR keystream with ROM, hand chars to checker
module rc4_decrypt_loop
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF,
    parameter int K_W     = 6
) (
    input  logic               clok,
    input  logic               reset,
    rc4_decrypt_loop_if.master bus
);

    localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN);

    state_t         state;
    state_t         nxt;
    logic [7:0]     i_q;
    logic [7:0]     j_q;
    logic [7:0]     si_q;
    logic [7:0]     sj_q;
    logic [7:0]     char_q;
    logic [K_W-1:0] k_q;
    logic [K_W-1:0] k_inc;
    logic [7:0]     f_addr;

    assign k_inc  = k_q + K_W'(1);
    assign f_addr = si_q + sj_q;

    always_ff @(posedge clok) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // start_over outranks every other input, including a same-cycle go or accept
    always_comb begin
        nxt = state;
        if (bus.start_over) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (bus.go) nxt = ST_NEXT_I;
                ST_NEXT_I:   nxt = ST_RD_SI;
                ST_RD_SI:    nxt = ST_WAIT_SI;
                ST_WAIT_SI:  nxt = ST_RD_SJ;
                ST_RD_SJ:    nxt = ST_WAIT_SJ;
                ST_WAIT_SJ:  nxt = ST_WR_SI;
                ST_WR_SI:    nxt = ST_WR_SJ;
                ST_WR_SJ:    nxt = ST_RD_F;
                ST_RD_F:     nxt = ST_WAIT_F;
                ST_WAIT_F:   nxt = ST_WR_DR;
                ST_WR_DR:    nxt = ST_WAIT_ACK;
                ST_WAIT_ACK: if (bus.compared_char) nxt = (k_inc == K_LAST) ? ST_DONE : ST_NEXT_I;
                ST_DONE:     if (bus.go) nxt = ST_NEXT_I;
                default:     nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clok) begin
        if (reset || bus.start_over) begin
            i_q    <= '0;
            j_q    <= '0;
            si_q   <= '0;
            sj_q   <= '0;
            char_q <= '0;
            k_q    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.go) begin
                        i_q <= '0;
                        j_q <= '0;
                        k_q <= '0;
                    end
                end
                ST_NEXT_I:  i_q <= i_q + 8'd1;
                ST_WAIT_SI: begin
                    si_q <= bus.s_rddata;
                    j_q  <= j_q + bus.s_rddata;
                end
                ST_WAIT_SJ: sj_q <= bus.s_rddata;
                ST_WAIT_F:  char_q <= bus.s_rddata ^ bus.rom_rddata;
                ST_WAIT_ACK: if (bus.compared_char) k_q <= k_inc;
                default: ;
            endcase
        end
    end

    // Addresses are held through the wait states so the read word stays aligned with its address
    always_comb begin
        bus.s_addr    = '0;
        bus.s_wrdata  = '0;
        bus.s_wren    = 1'b0;
        bus.rom_addr  = '0;
        bus.dr_addr   = '0;
        bus.dr_wrdata = '0;
        bus.dr_wren   = 1'b0;
        bus.new_char  = 1'b0;
        bus.done      = (state == ST_DONE);
        bus.char_out  = char_q;
        bus.k         = k_q;
        case (state)
            ST_RD_SI, ST_WAIT_SI: bus.s_addr = i_q;
            ST_RD_SJ, ST_WAIT_SJ: bus.s_addr = j_q;
            ST_WR_SI: begin
                bus.s_addr   = i_q;
                bus.s_wrdata = sj_q;
                bus.s_wren   = 1'b1;
            end
            ST_WR_SJ: begin
                bus.s_addr   = j_q;
                bus.s_wrdata = si_q;
                bus.s_wren   = 1'b1;
            end
            ST_RD_F, ST_WAIT_F: begin
                bus.s_addr   = f_addr;
                bus.rom_addr = k_q[MSG_AW-1:0];
            end
            ST_WR_DR: begin
                bus.dr_addr   = k_q[MSG_AW-1:0];
                bus.dr_wrdata = char_q;
                bus.dr_wren   = 1'b1;
                bus.new_char  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_decrypt_loop.sv
// tb/tb_rc4_decrypt_loop.sv - scoreboard bench for rc4_decrypt_loop against a software RC4 model
`timescale 1ns/1ps
module tb_rc4_decrypt_loop;

    logic clok = 1'b0;
    logic reset;

    always #5 clok = ~clok;

    rc4_decrypt_loop_if #(.K_W(6)) bus ();

    rc4_decrypt_loop #(.MSG_LEN(32), .K_W(6)) dut (
        .clok  (clok),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] s_mem   [256];
    logic [7:0] s_init  [256];
    logic [7:0] rom_mem [32];
    logic [7:0] dr_mem  [32];
    logic [7:0] exp_out [32];
    logic [7:0] s_rd;
    logic [7:0] rom_rd;

    assign bus.s_rddata   = s_rd;
    assign bus.rom_rddata = rom_rd;

    always @(posedge clok) begin
        s_rd   <= s_mem[bus.s_addr];
        rom_rd <= rom_mem[bus.rom_addr];
        if (bus.s_wren)  s_mem[bus.s_addr]   = bus.s_wrdata;
        if (bus.dr_wren) dr_mem[bus.dr_addr] = bus.dr_wrdata;
    end

    logic [51:0] all_outs;
    assign all_outs = {bus.s_addr, bus.s_wrdata, bus.s_wren, bus.rom_addr, bus.dr_addr,
                       bus.dr_wrdata, bus.dr_wren, bus.char_out, bus.new_char, bus.k, bus.done};

    typedef struct {
        logic [7:0] ch;
        int         idx;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   nc_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every new_char pulse must match the head of the scoreboard
    always @(negedge clok) begin
        if (!reset && bus.new_char) begin
            exp_t e;
            nc_count++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_new_char: got char %0h expected no pulse", bus.char_out);
            end else begin
                e = sb_q.pop_front();
                chk("char_out", 64'(bus.char_out), 64'(e.ch));
                chk("dr_wrdata", 64'(bus.dr_wrdata), 64'(e.ch));
                chk("dr_addr", 64'(bus.dr_addr), 64'(e.idx));
                chk("dr_wren", 64'(bus.dr_wren), 64'd1);
            end
        end
    end

    // mode 0: identity, 1: reversed, 2: random permutation
    task automatic load_s(input int mode);
        for (int x = 0; x < 256; x++) begin
            if (mode == 1) s_init[x] = 8'(255 - x);
            else           s_init[x] = 8'(x);
        end
        if (mode == 2) begin
            for (int x = 255; x > 0; x--) begin
                int r;
                logic [7:0] t;
                r = $urandom_range(x, 0);
                t = s_init[x];
                s_init[x] = s_init[r];
                s_init[r] = t;
            end
        end
        for (int x = 0; x < 256; x++) s_mem[x] = s_init[x];
        for (int x = 0; x < 32; x++) dr_mem[x] = 8'h00;
    endtask

    task automatic load_rom(input int mode);
        for (int x = 0; x < 32; x++) rom_mem[x] = (mode == 0) ? 8'h00 : 8'($urandom);
    endtask

    // Textbook RC4 keystream over a private copy of the starting S-box
    task automatic compute_exp();
        int s[256];
        int i;
        int j;
        int t;
        for (int x = 0; x < 256; x++) s[x] = int'(s_init[x]);
        i = 0;
        j = 0;
        for (int n = 0; n < 32; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            exp_out[n] = 8'(s[(s[i] + s[j]) % 256]) ^ rom_mem[n];
        end
    endtask

    task automatic push_exp(input int n);
        for (int x = 0; x < n; x++) begin
            exp_t e;
            e.ch  = exp_out[x];
            e.idx = x;
            sb_q.push_back(e);
        end
    endtask

    task automatic do_go();
        @(negedge clok);
        bus.go = 1'b1;
        @(negedge clok);
        bus.go = 1'b0;
    endtask

    task automatic wait_nc(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clok);
            if (bus.new_char) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL new_char_timeout: got no pulse expected one within 200 cycles");
        end
    endtask

    task automatic ack_chars(input int n, input int inject_go);
        bit ok;
        for (int x = 0; x < n; x++) begin
            wait_nc(ok);
            if (!ok) return;
            @(negedge clok);
            if (x == inject_go) begin
                bus.go = 1'b1;
                @(negedge clok);
                bus.go = 1'b0;
            end
            repeat ($urandom_range(3, 0)) @(negedge clok);
            bus.compared_char = 1'b1;
            @(negedge clok);
            bus.compared_char = 1'b0;
        end
    endtask

    task automatic check_dr(input string name);
        int bad;
        bad = 0;
        for (int x = 0; x < 32; x++) if (dr_mem[x] !== exp_out[x]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    task automatic check_quiet(input string name, input int cycles);
        int act;
        act = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clok);
            if (bus.s_wren || bus.dr_wren || bus.new_char) act++;
        end
        chk(name, 64'(act), 64'd0);
    endtask

    task automatic full_run(input int smode, input string tag);
        load_s(smode);
        load_rom(1);
        compute_exp();
        push_exp(32);
        nc_count = 0;
        do_go();
        ack_chars(32, int'($urandom_range(31, 0)));
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_k"}, 64'(bus.k), 64'd32);
        chk({tag, "_pulses"}, 64'(nc_count), 64'd32);
        check_dr({tag, "_dr"});
    endtask

    initial begin
        bit ok;
        int wcnt;
        reset             = 1'b1;
        bus.go            = 1'b0;
        bus.start_over    = 1'b0;
        bus.compared_char = 1'b0;
        load_s(0);
        load_rom(0);
        repeat (3) @(negedge clok);
        reset = 1'b0;
        @(negedge clok);
        chk("reset_outputs", 64'(all_outs), 64'd0);

        // Identity S, zero ROM, full message; a stray go lands mid-run
        load_s(0);
        load_rom(0);
        compute_exp();
        push_exp(32);
        nc_count = 0;
        do_go();
        ack_chars(32, 3);
        chk("id_done", 64'(bus.done), 64'd1);
        chk("id_k", 64'(bus.k), 64'd32);
        chk("id_pulses", 64'(nc_count), 64'd32);
        chk("id_dr0", 64'(dr_mem[0]), 64'h02);
        check_dr("id_dr");

        // Restart from DONE; ROM[0]=0x63 gives 'a'; i==j swap leaves S intact
        load_s(0);
        load_rom(1);
        rom_mem[0] = 8'h63;
        compute_exp();
        push_exp(1);
        nc_count = 0;
        do_go();
        wait_nc(ok);
        @(negedge clok);
        chk("char_a", 64'(bus.char_out), 64'h61);
        chk("s1_after_swap", 64'(s_mem[1]), 64'd1);
        chk("s2_after_swap", 64'(s_mem[2]), 64'd2);
        bus.start_over = 1'b1;
        @(negedge clok);
        bus.start_over = 1'b0;
        repeat (5) @(negedge clok);
        chk("a_pulses", 64'(nc_count), 64'd1);

        // Abort at char 5; a go held with start_over must be ignored
        load_s(2);
        load_rom(1);
        compute_exp();
        push_exp(6);
        do_go();
        ack_chars(5, -1);
        wait_nc(ok);
        @(negedge clok);
        bus.start_over = 1'b1;
        @(negedge clok);
        chk("abort_k", 64'(bus.k), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_char", 64'(bus.char_out), 64'd0);
        bus.go = 1'b1;
        @(negedge clok);
        bus.go         = 1'b0;
        bus.start_over = 1'b0;
        check_quiet("abort_quiet", 20);
        chk("abort_sb_empty", 64'(sb_q.size()), 64'd0);

        // Accept and abort in the same cycle; abort wins, then clean restart
        load_s(2);
        load_rom(1);
        compute_exp();
        push_exp(4);
        do_go();
        ack_chars(3, -1);
        wait_nc(ok);
        @(negedge clok);
        bus.start_over    = 1'b1;
        bus.compared_char = 1'b1;
        @(negedge clok);
        bus.start_over    = 1'b0;
        bus.compared_char = 1'b0;
        chk("both_k", 64'(bus.k), 64'd0);
        check_quiet("both_quiet", 5);
        full_run(0, "rego");

        // Reset while WR_SJ is active
        load_s(0);
        load_rom(0);
        do_go();
        wcnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.s_wren) wcnt++;
            if (wcnt == 2) break;
            @(negedge clok);
        end
        chk("reached_wr_sj", 64'(wcnt), 64'd2);
        reset = 1'b1;
        @(negedge clok);
        chk("midreset_outputs", 64'(all_outs), 64'd0);
        chk("midreset_s_wren", 64'(bus.s_wren), 64'd0);
        reset = 1'b0;
        load_s(0);
        compute_exp();
        push_exp(1);
        do_go();
        wait_nc(ok);
        chk("post_reset_char", 64'(bus.char_out), 64'h02);
        @(negedge clok);
        bus.start_over = 1'b1;
        @(negedge clok);
        bus.start_over = 1'b0;

        // Reversed S exercises i/j wrap; then random permutations
        full_run(1, "rev");
        full_run(2, "rnd0");
        full_run(2, "rnd1");
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion before 2ms");
        $fatal(1, "watchdog");
    end

endmodule
